// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: shared widths and the
// push/pop op encoding used by the fetch queue.
package if_fetch_queue_pkg;

  localparam int ADDRESS_LEN     = 32;
  localparam int INSTRUCTION_LEN = 32;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'b00,
    FQ_POP  = 2'b01,
    FQ_PUSH = 2'b10,
    FQ_BOTH = 2'b11
  } fq_op_e;

endpackage

// File: rtl/if_queue_ptr.sv
// if_queue_ptr: wrap-around queue pointer.
// Ports: clk, rst_i/clr_i (sync clear), inc_i (advance), ptr_o.
module if_queue_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Power-of-two depth: the natural overflow is the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (rst_i || clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: DEPTH-entry {PC, Instruction} buffer between IF and ID.
// Ports: clk, rst, flush; in_valid/in_ready + PC_in/Instruction_in (push);
// out_valid/out_ready + PC/Instruction (head, zero when empty); count.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter  int ADDR_W  = ADDRESS_LEN,
  parameter  int INSTR_W = INSTRUCTION_LEN,
  parameter  int DEPTH   = 4,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  PC_in,
  input  logic [INSTR_W-1:0] Instruction_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] Instruction,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  pc_q  [DEPTH];
  logic [INSTR_W-1:0] ins_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic   push;
  logic   pop;
  logic   wr_en;
  logic   rd_en;
  fq_op_e op;

  // in_ready is a function of occupancy only, so a full
  // queue refuses a push even if the head leaves this cycle.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // A flush drops whatever transfer was offered alongside it.
  assign wr_en = push & ~flush;
  assign rd_en = pop & ~flush;
  assign op    = fq_op_e'({wr_en, rd_en});

  if_queue_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_i (rst),
    .clr_i (flush),
    .inc_i (wr_en),
    .ptr_o (wr_ptr)
  );

  if_queue_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_i (rst),
    .clr_i (flush),
    .inc_i (rd_en),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    unique case (op)
      FQ_PUSH: count_d = count_q + CNT_W'(1);
      FQ_POP:  count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else if (wr_en) begin
      pc_q[wr_ptr]  <= PC_in;
      ins_q[wr_ptr] <= Instruction_in;
    end
  end

  // Empty queue looks like a flushed IF/ID register.
  assign PC          = out_valid ? pc_q[rd_ptr]  : '0;
  assign Instruction = out_valid ? ins_q[rd_ptr] : '0;
  assign count       = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: scoreboard bench for if_fetch_queue.
// Stimulus records expected pairs; a negedge monitor checks the head.
module tb_if_fetch_queue;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b1;
  logic          in_ready;
  logic [AW-1:0] PC_in = 32'h100;
  logic [IW-1:0] Instruction_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] PC;
  logic [IW-1:0] Instruction;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] sb_pc [$];
  logic [IW-1:0] sb_in [$];

  if_fetch_queue #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .PC_in          (PC_in),
    .Instruction_in (Instruction_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .PC             (PC),
    .Instruction    (Instruction),
    .count          (count)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] ins_of(input logic [AW-1:0] p);
    return {p[15:0], 16'h0013} ^ 32'hDEAD0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares head and flags against the scoreboard.
  always @(negedge clk) begin
    chk("count", 64'(count), 64'(sb_pc.size()));
    chk("out_valid", 64'(out_valid), 64'(sb_pc.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(sb_pc.size() != D));
    if (sb_pc.size() == 0) begin
      chk("bubble_pc", 64'(PC), 64'd0);
      chk("bubble_ins", 64'(Instruction), 64'd0);
    end else begin
      chk("head_pc", 64'(PC), 64'(sb_pc[0]));
      chk("head_ins", 64'(Instruction), 64'(sb_in[0]));
      if (out_ready && !flush && !rst) begin
        void'(sb_pc.pop_front());
        void'(sb_in.pop_front());
      end
    end
  end

  // One cycle: drive after posedge, record the transfer after negedge.
  task automatic step(input logic iv, input logic [AW-1:0] p,
                      input logic ordy, input logic fl, input logic r,
                      output logic pushed);
    @(posedge clk);
    #1;
    in_valid       = iv;
    PC_in          = p;
    Instruction_in = ins_of(p);
    out_ready      = ordy;
    flush          = fl;
    rst            = r;
    @(negedge clk);
    #1;
    pushed = iv && in_ready && !fl && !r;
    if (fl || r) begin
      sb_pc.delete();
      sb_in.delete();
    end else if (pushed) begin
      sb_pc.push_back(p);
      sb_in.push_back(ins_of(p));
    end
  endtask

  logic pd;

  initial begin
    int issued;
    int cyc;
    logic [31:0] pat_i;
    logic [31:0] pat_o;

    // Reset held two cycles with in_valid high.
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, pd);
    step(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, pd);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pd);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(PC), 64'd0);
    chk("rst_ins", 64'(Instruction), 64'd0);
    chk("rst_iready", 64'(in_ready), 64'd1);

    // Fill while frozen, refuse fifth, then drain.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, pd);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pd);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_iready", 64'(in_ready), 64'd0);
    chk("fill_head", 64'(PC), 64'h0);
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, pd);
    chk("fifth_refused", 64'(pd), 64'd0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);
    chk("drain_ovalid", 64'(out_valid), 64'd0);

    // Streaming from empty.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 32'h200 + 32'(4 * k), 1'b1, 1'b0, 1'b0, pd);
      if (k >= 2) begin
        chk("stream_count", 64'(count), 64'd1);
        chk("stream_pc", 64'(PC), 64'(32'h200 + 32'(4 * (k - 1))));
      end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);
    chk("stream_empty", 64'(count), 64'd0);

    // Wrap-around with a fixed stall pattern.
    pat_i  = 32'b1011_0111_1101_1111_0110_1110_1011_1101;
    pat_o  = 32'b0100_1100_0011_1010_0101_1001_1100_0110;
    issued = 0;
    cyc    = 0;
    while (issued < 10 && cyc < 60) begin
      step(pat_i[cyc % 32], 32'h300 + 32'(issued * 4),
           pat_o[cyc % 32], 1'b0, 1'b0, pd);
      if (pd) issued++;
      cyc++;
    end
    chk("wrap_issued", 64'(issued), 64'd10);
    cyc = 0;
    while (sb_pc.size() != 0 && cyc < 20) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);
      cyc++;
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);
    chk("wrap_drained", 64'(sb_pc.size()), 64'd0);

    // Flush at count=3 with push and pop offered.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0, 1'b0, pd);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pd);
    chk("pre_flush_count", 64'(count), 64'd3);
    step(1'b1, 32'hBAD0, 1'b1, 1'b1, 1'b0, pd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ovalid", 64'(out_valid), 64'd0);
    chk("flush_pc", 64'(PC), 64'd0);
    chk("flush_iready", 64'(in_ready), 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);

    // Full + pop in the same cycle: pop only.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0, 1'b0, pd);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pd);
    chk("full_count", 64'(count), 64'd4);
    step(1'b1, 32'h5F0, 1'b1, 1'b0, 1'b0, pd);
    chk("full_pop_refused", 64'(pd), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pd);
    chk("full_pop_count", 64'(count), 64'd3);
    chk("full_pop_iready", 64'(in_ready), 64'd1);
    chk("full_pop_head", 64'(PC), 64'h504);

    // Reset mid-stream behaves like flush.
    step(1'b1, 32'h600, 1'b1, 1'b0, 1'b1, pd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_pc", 64'(PC), 64'd0);
    step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, pd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);
    chk("post_rst_head", 64'(PC), 64'h700);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, pd);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, pd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch buffer between the IF stage and ID stage, replacing the single-entry IF/ID pipeline register. Holds up to DEPTH {PC, Instruction} pairs in a circular buffer. Uses valid/ready handshakes so fetch can run ahead while decode is frozen. Supports a single-cycle flush for branch redirects.

## Interface
- ADDR_W, default 32 (ADDRESS_LEN): PC width.
- INSTR_W, default 32: instruction word width.
- DEPTH, default 4: number of entries; power of two, ≥2.
- CNT_W, derived $clog2(DEPTH+1): occupancy counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (branch taken).
- in_valid  in  1  IF stage presents a fetched pair.
- in_ready  out  1  queue accepts a pair this cycle; equals (count != DEPTH).
- PC_in  in  ADDR_W  PC of the fetched instruction.
- Instruction_in  in  INSTR_W  fetched instruction word.
- out_valid  out  1  head entry is valid; equals (count != 0).
- out_ready  in  1  ID stage consumes the head; the pipeline drives ~freeze.
- PC  out  ADDR_W  PC of the head entry.
- Instruction  out  INSTR_W  instruction of the head entry.
- count  out  CNT_W  current occupancy.

## Operation
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Storage is DEPTH entries of {PC, Instruction}, addressed by wr_ptr and rd_ptr, each $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0.
- push: write the entry at wr_ptr, then wr_ptr+1.
- pop: rd_ptr+1.
- count update: count += push − pop. Simultaneous push and pop leaves count unchanged.
- in_ready depends only on count, with no combinational path from out_ready. A full queue refuses a push even when a pop occurs in the same cycle.
- Output mux: PC/Instruction = entry[rd_ptr] when out_valid, else all zeros. An empty queue presents a zero bubble, identical to a flushed IF/ID register.
- Priority, highest first:
  - rst: pointers, count and all storage cleared to 0.
  - flush: wr_ptr, rd_ptr and count cleared to 0. Any push/pop that cycle is ignored. Storage contents are don't-care.
  - normal push/pop.
- No state machine. State is {wr_ptr, rd_ptr, count, storage}.

## Timing
- Reset values: in_ready=1, out_valid=0, PC=0, Instruction=0, count=0.
- Latency: a pair pushed at edge N is visible on PC/Instruction after edge N (one-cycle latency, as with the old register). Pairs leave in FIFO order.
- Throughput: one push and one pop per cycle, sustained.
- After flush is asserted at edge N: out_valid=0 and outputs are zero from edge N. in_ready=1 from edge N.
- A push accepted in the flush cycle is lost by design; IF re-fetches from the redirected PC.
- rst asserted mid-stream has the same visible effect as flush. Storage is also zeroed.
- Freeze of arbitrary length (out_ready=0) holds the head stable. The queue fills to DEPTH, then in_ready=0.

## Structure
- ADDRESS_LEN (32) and INSTRUCTION_LEN (32) live in the shared defines file and feed ADDR_W/INSTR_W.
- One natural sub-module: if_queue_ptr, a wrap-around pointer with synchronous rst/clr and an increment enable. It is instantiated twice (wr/rd).
- Storage is a plain register array inside if_fetch_queue; no memory macro.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → count=0, out_valid=0, PC=0, Instruction=0, in_ready=1.
- Fill/drain, DEPTH=4: push PCs 0x00,0x04,0x08,0x0C with out_ready=0 → count=4, in_ready=0. A fifth push of 0x10 is refused. Then out_ready=1 → PCs appear 0x00,0x04,0x08,0x0C on consecutive cycles, then out_valid=0.
- Streaming: in_valid=out_ready=1 continuously from empty, PCs +4 per cycle → count settles at 1, each PC emerges exactly one cycle after push, no gaps.
- Wrap-around: push/pop 10 entries through DEPTH=4 with random stalls → output order matches input order, no duplicates or drops.
- Flush with simultaneous push/pop at count=3 → next cycle count=0, out_valid=0, PC=0. The pair offered in the flush cycle never appears.
- Full + pop same cycle: count=4, out_ready=1, in_valid=1 → pop only, count=3, in_ready=1 next cycle.
